// File: rtl/bd_rx_frame_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bd_rx_pkg
//  Description : Shared types, default widths and helpers for the baseband
//                RX frame buffer (bd_rx_frame_fifo and its serialiser).
//  Contents    : lane_t      - one lane byte at the default DATA_W
//                tx_state_e  - output serialiser state
//                f_even_par  - even-parity bit of a (zero-extended) lane
//  Revision    : 1.0 - initial release
// ============================================================================
package bd_rx_pkg;

    localparam int C_DEF_DATA_W = 8;
    localparam int C_DEF_CNT_W  = 8;

    typedef logic [C_DEF_DATA_W-1:0] lane_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Parity bit that makes the lane plus its parity bit contain an even
    // number of ones. Lanes wider than 64 bits are not supported.
    function automatic logic f_even_par(input logic [63:0] i_bits);
        return ^i_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bd_rx_frame_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : bd_rx_frame_fifo_if
//  Description : Host-side valid/ready byte stream of the RX frame buffer.
//  Signals     : valid_out  - data_out holds a byte
//                data_out   - current lane byte (DATA_W)
//                last_out   - final lane of a frame
//                ready_out  - host accepts the byte on valid_out & ready_out
//  Modports    : master (frame buffer side), slave (host side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bd_rx_frame_fifo_if #(
    parameter int DATA_W = 8
);
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              last_out;
    logic              ready_out;

    modport master (output valid_out, output data_out, output last_out, input ready_out);
    modport slave  (input  valid_out, input  data_out, input  last_out, output ready_out);
endinterface
`default_nettype wire

// File: rtl/bd_rx_frame_ser.sv
`default_nettype none
// ============================================================================
//  Module      : bd_rx_frame_ser
//  Description : Frame shift register, lane counter and output FSM. Pulls one
//                frame from the store when available and emits it lane 0
//                first on a valid/ready byte stream with registered outputs.
//  Ports       : clk, reset (sync, active-low)
//                i_avail    - store holds at least one frame
//                i_pop_data - frame at the store read pointer
//                o_pop      - frame taken from the store this cycle
//                i_ready / o_valid / o_data / o_last - host byte stream
//  Revision    : 1.0 - initial release
// ============================================================================
module bd_rx_frame_ser
    import bd_rx_pkg::*;
#(
    parameter int DATA_W    = C_DEF_DATA_W,
    parameter int NUM_LANES = 2
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          i_avail,
    input  wire logic [NUM_LANES*DATA_W-1:0]   i_pop_data,
    output logic                               o_pop,
    input  wire logic                          i_ready,
    output logic                               o_valid,
    output logic [DATA_W-1:0]                  o_data,
    output logic                               o_last
);

    localparam int                FRAME_W     = NUM_LANES * DATA_W;
    localparam int                LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(NUM_LANES - 1);

    tx_state_e           r_state_q, w_state_d;
    logic [FRAME_W-1:0]  r_frame_q, w_frame_d, w_frame_shr;
    logic [LANE_W-1:0]   r_lane_q, w_lane_d, w_lane_nx;
    logic                r_valid_q, w_valid_d;
    logic                r_last_q, w_last_d;
    logic [DATA_W-1:0]   r_data_q, w_data_d;

    assign w_frame_shr = r_frame_q >> DATA_W;
    assign w_lane_nx   = r_lane_q + LANE_W'(1);

    always_comb begin
        w_state_d = r_state_q;
        w_frame_d = r_frame_q;
        w_lane_d  = r_lane_q;
        w_valid_d = r_valid_q;
        w_last_d  = r_last_q;
        w_data_d  = r_data_q;
        o_pop     = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (i_avail) begin
                    o_pop     = 1'b1;
                    w_frame_d = i_pop_data;
                    w_lane_d  = '0;
                    w_state_d = SEND;
                end
            end
            SEND: begin
                if (!r_valid_q) begin
                    // First cycle after leaving IDLE: present lane 0.
                    w_valid_d = 1'b1;
                    w_data_d  = r_frame_q[DATA_W-1:0];
                    w_last_d  = (r_lane_q == C_LAST_LANE);
                end else if (i_ready) begin
                    if (!r_last_q) begin
                        w_lane_d  = w_lane_nx;
                        w_frame_d = w_frame_shr;
                        w_data_d  = w_frame_shr[DATA_W-1:0];
                        w_last_d  = (w_lane_nx == C_LAST_LANE);
                    end else if (i_avail) begin
                        // Back-to-back: next frame's lane 0 follows with no bubble.
                        o_pop     = 1'b1;
                        w_frame_d = i_pop_data;
                        w_lane_d  = '0;
                        w_data_d  = i_pop_data[DATA_W-1:0];
                        w_last_d  = (C_LAST_LANE == '0);
                    end else begin
                        w_state_d = IDLE;
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= IDLE;
            r_lane_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_lane_q  <= w_lane_d;
            r_valid_q <= w_valid_d;
            r_last_q  <= w_last_d;
            r_data_q  <= w_data_d;
        end
    end

    // Frame holding register is datapath only.
    always_ff @(posedge clk) begin
        r_frame_q <= w_frame_d;
    end

    assign o_valid = r_valid_q;
    assign o_data  = r_data_q;
    assign o_last  = r_last_q;

endmodule
`default_nettype wire

// File: rtl/bd_rx_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bd_rx_frame_fifo
//  Description : Baseband RX frame buffer. Stores decoded multi-lane frames in
//                a DEPTH-deep circular store and serialises them lane 0 first
//                to the host; raises int_rx_host from fill level / overflow.
//  Ports       : G_CLK_RX, reset (sync, active-low)
//                frame_valid, frame_data  - decoded frame strobe + lanes
//                irq_thresh, ovf_clr      - interrupt level, overflow clear
//                fill, overflow, drop_cnt, int_rx_host - status
//                host (master)            - valid/ready byte stream
//  Option      : BD_RX_PARITY_EN adds frame_par input and par_err_cnt output;
//                frames failing even parity on any lane are discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module bd_rx_frame_fifo
    import bd_rx_pkg::*;
#(
    parameter int DATA_W    = C_DEF_DATA_W,
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = C_DEF_CNT_W
) (
    input  wire logic                         G_CLK_RX,
    input  wire logic                         reset,
    input  wire logic                         frame_valid,
    input  wire logic [NUM_LANES*DATA_W-1:0]  frame_data,
`ifdef BD_RX_PARITY_EN
    input  wire logic [NUM_LANES-1:0]         frame_par,
    output logic [CNT_W-1:0]                  par_err_cnt,
`endif
    input  wire logic [$clog2(DEPTH):0]       irq_thresh,
    input  wire logic                         ovf_clr,
    output logic [$clog2(DEPTH):0]            fill,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  drop_cnt,
    output logic                              int_rx_host,
    bd_rx_frame_fifo_if.master                host
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int FRAME_W = NUM_LANES * DATA_W;

    logic [FRAME_W-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d, r_rd_ptr_q, w_rd_ptr_d, w_fill;
    logic               r_ovf_q, w_ovf_d, r_int_q, w_int_d;
    logic [CNT_W-1:0]   r_drop_q, w_drop_d;
    logic               w_good, w_empty, w_full, w_pop, w_push, w_drop;
    logic [FRAME_W-1:0] w_rd_data;

`ifdef BD_RX_PARITY_EN
    logic               w_par_bad;
    logic [CNT_W-1:0]   r_perr_q, w_perr_d;

    always_comb begin
        w_par_bad = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (f_even_par(64'(frame_data[i*DATA_W +: DATA_W])) != frame_par[i]) begin
                w_par_bad = 1'b1;
            end
        end
        w_perr_d = r_perr_q;
        if (frame_valid && w_par_bad && (r_perr_q != '1)) begin
            w_perr_d = r_perr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge G_CLK_RX) begin
        if (!reset) r_perr_q <= '0;
        else        r_perr_q <= w_perr_d;
    end

    assign w_good      = frame_valid & ~w_par_bad;
    assign par_err_cnt = r_perr_q;
`else
    assign w_good      = frame_valid;
`endif

    // Extra pointer MSB separates full from empty when the indices match.
    assign w_fill  = r_wr_ptr_q - r_rd_ptr_q;
    assign w_empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign w_full  = (r_wr_ptr_q[ADDR_W] != r_rd_ptr_q[ADDR_W]) &&
                     (r_wr_ptr_q[ADDR_W-1:0] == r_rd_ptr_q[ADDR_W-1:0]);

    // A pop in the same cycle frees the slot the new frame needs.
    assign w_push    = w_good & (~w_full | w_pop);
    assign w_drop    = w_good & w_full & ~w_pop;
    assign w_rd_data = r_mem_q[r_rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        w_wr_ptr_d = w_push ? r_wr_ptr_q + PTR_W'(1) : r_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? r_rd_ptr_q + PTR_W'(1) : r_rd_ptr_q;
        // Set has priority over clear.
        w_ovf_d    = w_drop ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf_q);
        w_drop_d   = (w_drop && (r_drop_q != '1)) ? r_drop_q + CNT_W'(1) : r_drop_q;
        w_int_d    = r_ovf_q | ((irq_thresh != '0) && (w_fill >= irq_thresh));
    end

    always_ff @(posedge G_CLK_RX) begin
        if (!reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_ovf_q    <= 1'b0;
            r_drop_q   <= '0;
            r_int_q    <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_ovf_q    <= w_ovf_d;
            r_drop_q   <= w_drop_d;
            r_int_q    <= w_int_d;
        end
    end

    always_ff @(posedge G_CLK_RX) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q[ADDR_W-1:0]] <= frame_data;
        end
    end

    bd_rx_frame_ser #(
        .DATA_W    (DATA_W),
        .NUM_LANES (NUM_LANES)
    ) u_ser (
        .clk        (G_CLK_RX),
        .reset      (reset),
        .i_avail    (~w_empty),
        .i_pop_data (w_rd_data),
        .o_pop      (w_pop),
        .i_ready    (host.ready_out),
        .o_valid    (host.valid_out),
        .o_data     (host.data_out),
        .o_last     (host.last_out)
    );

    assign fill        = w_fill;
    assign overflow    = r_ovf_q;
    assign drop_cnt    = r_drop_q;
    assign int_rx_host = r_int_q;

endmodule
`default_nettype wire

// File: tb/tb_bd_rx_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bd_rx_frame_fifo
//  Description : Self-checking bench for bd_rx_frame_fifo. A queue-based
//                reference model predicts accepted frames, status and stream
//                timing; a negedge monitor checks each handshaken byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bd_rx_frame_fifo;
    import bd_rx_pkg::*;

    localparam int DW     = 8;
    localparam int NL     = 2;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int FW     = NL * DW;
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_valid;
    logic [FW-1:0]     frame_data;
    logic [FILL_W-1:0] irq_thresh;
    logic              ovf_clr;
    logic [FILL_W-1:0] fill;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic              int_rx_host;
`ifdef BD_RX_PARITY_EN
    logic [NL-1:0]     frame_par;
    logic [CNT_W-1:0]  par_err_cnt;
`endif

    bd_rx_frame_fifo_if #(.DATA_W(DW)) host ();

    bd_rx_frame_fifo #(
        .DATA_W(DW), .NUM_LANES(NL), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .G_CLK_RX    (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
`ifdef BD_RX_PARITY_EN
        .frame_par   (frame_par),
        .par_err_cnt (par_err_cnt),
`endif
        .irq_thresh  (irq_thresh),
        .ovf_clr     (ovf_clr),
        .fill        (fill),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .int_rx_host (int_rx_host),
        .host        (host)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic l; lane_t d; } exp_t;
    exp_t          exp_q[$];
    logic [FW-1:0] m_q[$];
    bit            m_busy, m_vis, m_ovf, m_int;
    int            m_lane, m_drop, m_perr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NL-1:0] par_of(input logic [FW-1:0] f);
        logic [NL-1:0] p;
        p = '0;
        for (int i = 0; i < NL; i++) p[i] = ^f[i*DW +: DW];
        return p;
    endfunction

    // One clock: sample inputs, advance the model at the edge, check status.
    task automatic tick();
        bit fv, rdy, clr, rst_n, good, hs, lastl, pop, drop;
        logic [FW-1:0] fd;
        int thr, sz;
        fv = frame_valid; rdy = host.ready_out; clr = ovf_clr; rst_n = reset;
        fd = frame_data; thr = int'(irq_thresh);
        good = fv;
`ifdef BD_RX_PARITY_EN
        if (fv && (frame_par != par_of(fd))) begin
            good = 1'b0;
            if (m_perr < CMAX) m_perr++;
        end
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete(); exp_q.delete();
            m_busy = 0; m_vis = 0; m_lane = 0; m_ovf = 0; m_drop = 0; m_int = 0; m_perr = 0;
        end else begin
            sz    = m_q.size();
            hs    = m_vis && rdy;
            lastl = (m_lane == NL - 1);
            pop   = (!m_busy || (hs && lastl)) && (sz > 0);
            drop  = good && (sz == DEPTH) && !pop;
            m_int = m_ovf || (thr != 0 && sz >= thr);
            if (drop) begin
                m_ovf = 1;
                if (m_drop < CMAX) m_drop++;
            end else if (clr) begin
                m_ovf = 0;
            end
            if (hs && !lastl) m_lane++;
            if (pop) begin
                void'(m_q.pop_front());
                m_vis  = m_busy;
                m_busy = 1;
                m_lane = 0;
            end else if (hs && lastl) begin
                m_busy = 0; m_vis = 0;
            end else if (m_busy && !m_vis) begin
                m_vis = 1;
            end
            if (good && !drop) begin
                m_q.push_back(fd);
                for (int i = 0; i < NL; i++) exp_q.push_back({(i == NL - 1), fd[i*DW +: DW]});
            end
        end
        #1;
        chk("valid_out", host.valid_out, m_vis);
        chk("fill", fill, m_q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("int_rx_host", int_rx_host, m_int);
`ifdef BD_RX_PARITY_EN
        chk("par_err_cnt", par_err_cnt, m_perr);
`endif
        if (m_vis && exp_q.size() > 0) begin
            chk("hold_data", host.data_out, exp_q[0].d);
            chk("hold_last", host.last_out, exp_q[0].l);
        end
    endtask

    task automatic drive(input bit fv, input bit rdy, input bit clr, input bit badpar);
        frame_valid    = fv;
        frame_data     = FW'($urandom);
        host.ready_out = rdy;
        ovf_clr        = clr;
`ifdef BD_RX_PARITY_EN
        frame_par = par_of(frame_data);
        if (badpar) frame_par[$urandom_range(0, NL - 1)] ^= 1'b1;
`else
        if (badpar) frame_valid = fv;
`endif
        tick();
    endtask

    // Scoreboard monitor: a byte is consumed at the edge following a
    // negedge that sees valid & ready.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && host.valid_out === 1'b1 && host.ready_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stream_extra: got byte %0h expected none", host.data_out);
            end else begin
                e = exp_q.pop_front();
                chk("stream_data", host.data_out, e.d);
                chk("stream_last", host.last_out, e.l);
            end
        end
    end

    initial begin
        reset = 1'b0; frame_valid = 1'b0; frame_data = '0; irq_thresh = '0;
        ovf_clr = 1'b0; host.ready_out = 1'b0;
`ifdef BD_RX_PARITY_EN
        frame_par = '0;
`endif
        repeat (2) tick();
        chk("rst_data_out", host.data_out, 0);
        chk("rst_last_out", host.last_out, 0);
        reset = 1'b1;

        // Single known frame, lane 0 = A5, lane 1 = 3C.
        frame_valid = 1'b1; frame_data = 16'h3CA5; host.ready_out = 1'b1; ovf_clr = 1'b0;
`ifdef BD_RX_PARITY_EN
        frame_par = par_of(frame_data);
`endif
        tick();
        frame_valid = 1'b0;
        tick();
        chk("lat_not_yet", host.valid_out, 0);
        tick();
        chk("lat_byte0", host.data_out, 8'hA5);
        repeat (4) tick();

        // Stall mid-frame.
        drive(1, 1, 0, 0); drive(1, 1, 0, 0);
        repeat (2) drive(0, 1, 0, 0);
        repeat (5) drive(0, 0, 0, 0);
        repeat (8) drive(0, 1, 0, 0);

        // Overfill with host stalled, then clear overflow.
        irq_thresh = '0;
        repeat (DEPTH + 3) drive(1, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        chk("full_fill", fill, DEPTH);
        drive(0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0);

        // Full store, frames arriving while draining (including on last-lane handshakes).
        repeat (24) drive(1, 1, 0, 0);
        repeat (30) drive(0, 1, 0, 0);

        // Threshold interrupt.
        irq_thresh = FILL_W'(3);
        repeat (3) begin drive(1, 0, 0, 0); drive(0, 0, 0, 0); end
        repeat (3) drive(0, 0, 0, 0);
        repeat (20) drive(0, 1, 0, 0);

        // Reset mid-frame.
        drive(1, 1, 0, 0); drive(1, 1, 0, 0);
        repeat (3) drive(0, 1, 0, 0);
        reset = 1'b0;
        drive(0, 1, 0, 0);
        chk("midrst_valid", host.valid_out, 0);
        chk("midrst_fill", fill, 0);
        reset = 1'b1;
        drive(1, 1, 0, 1);
        repeat (6) drive(0, 1, 0, 0);

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            irq_thresh = (n % 100 == 0) ? FILL_W'($urandom_range(0, DEPTH)) : irq_thresh;
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 10);
        end

        // Drop counter saturation.
        irq_thresh = '0;
        repeat (CMAX + 20) drive(1, 0, 0, 0);
        repeat (40) drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        repeat (2) drive(0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
